// File: rtl/wb_pkg.sv
// Shared types and width defaults for the memory-to-writeback stage.
package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  // Default-width entry. The top module declares the same layout at its own
  // widths, so non-default DATA_W/REG_W builds still work.
  typedef struct packed {
    logic                 regwrite;
    logic [REG_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] result;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry in-order skid buffer with occupancy FSM; storage is type-generic.
//   state | meaning
//   EMPTY | no entry held, head outputs keep their last value
//   ONE   | head valid, tail unused
//   TWO   | head and tail valid, input stalled
module wb_skid_buf
  import wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_data,
  input  logic   flush,
  input  logic   out_ready,
  output logic   out_valid,
  output logic   pop,
  output entry_t head
);

  wb_state_t state_q, state_d;
  entry_t    head_q, head_d;
  entry_t    tail_q, tail_d;
  logic      push;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = in_data;
          end else if (push) begin
            state_d = TWO;
            tail_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            head_d  = tail_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign head = head_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: result mux, skid buffer, write qualification, retire count.
// Optional macro WB_FWD_EN adds head-entry forwarding compare ports (rsE/rtE -> fwdAE/fwdBE).
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validM,
  output logic              readyM,
  input  logic              RegWriteM,
  input  logic              MemToRegM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] readDataM,
  input  logic [REG_W-1:0]  WriteRegM,
  input  logic              flushW,
  input  logic              readyW,
  output logic              validW,
  output logic              RegWriteW,
  output logic [REG_W-1:0]  WriteRegW,
  output logic [DATA_W-1:0] ResultW,
`ifdef WB_FWD_EN
  input  logic [REG_W-1:0]  rsE,
  input  logic [REG_W-1:0]  rtE,
  output logic              fwdAE,
  output logic              fwdBE,
`endif
  output logic [31:0]       retiredW
);

  typedef struct packed {
    logic              regwrite;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] result;
  } entry_t;

  entry_t      push_entry;
  entry_t      head;
  logic        pop;
  logic        head_wr;
  logic [31:0] retired_q, retired_d;

  always_comb begin
    push_entry          = '0;
    push_entry.regwrite = RegWriteM;
    push_entry.rd       = WriteRegM;
    push_entry.result   = MemToRegM ? readDataM : ALUOutM;
  end

  wb_skid_buf #(
    .entry_t (entry_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (validM),
    .in_ready  (readyM),
    .in_data   (push_entry),
    .flush     (flushW),
    .out_ready (readyW),
    .out_valid (validW),
    .pop       (pop),
    .head      (head)
  );

  // Writes to register 0 are architecturally void but still retire.
  always_comb begin
    head_wr   = head.regwrite & (head.rd != '0);
    RegWriteW = validW & readyW & head_wr;
    WriteRegW = head.rd;
    ResultW   = head.result;
    retired_d = retired_q + {31'd0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign retiredW = retired_q;

`ifdef WB_FWD_EN
  always_comb begin
    fwdAE = validW & head_wr & (head.rd == rsE);
    fwdBE = validW & head_wr & (head.rd == rtE);
  end
`endif

endmodule
